// File: rtl/bool_op_stream.sv
`default_nettype none
// ============================================================================
// Module  : bool_op_stream
// Brief   : Pairs two streamed operand bytes and returns their boolean
//           AND/OR/NOT as one handshaked beat, with a wrapping beat count.
// Revision: 1.0 - initial release
// ============================================================================
module bool_op_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_and_o,
    output logic              out_or_o,
    output logic              out_not_o,
    output logic [CNT_W-1:0]  result_cnt_o
);

    localparam logic [1:0] c_s_wait_a = 2'd0;
    localparam logic [1:0] c_s_wait_b = 2'd1;
    localparam logic [1:0] c_s_out    = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_a;
    logic              r_and;
    logic              r_or;
    logic              r_not;
    logic [CNT_W-1:0]  r_cnt;

    logic w_a_true;
    logic w_b_true;
    logic w_in_xfer;
    logic w_out_xfer;

    // Handshake flags depend on the state register alone.
    assign in_ready_o  = (r_state == c_s_wait_a) || (r_state == c_s_wait_b);
    assign out_valid_o = (r_state == c_s_out);

    assign w_in_xfer  = in_valid_i && in_ready_o;
    assign w_out_xfer = out_valid_o && out_ready_i;
    assign w_a_true   = |r_a;
    assign w_b_true   = |in_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_s_wait_a;
            r_a     <= '0;
            r_and   <= 1'b0;
            r_or    <= 1'b0;
            r_not   <= 1'b0;
            r_cnt   <= '0;
        end else if (clr_i) begin
            // Result registers keep their last values; only the pair and count reset.
            r_state <= c_s_wait_a;
            r_a     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_s_wait_a: begin
                    if (w_in_xfer) begin
                        r_a     <= in_data_i;
                        r_state <= c_s_wait_b;
                    end
                end
                c_s_wait_b: begin
                    if (w_in_xfer) begin
                        r_and   <= w_a_true && w_b_true;
                        r_or    <= w_a_true || w_b_true;
                        r_not   <= !w_a_true;
                        r_state <= c_s_out;
                    end
                end
                c_s_out: begin
                    if (w_out_xfer) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= c_s_wait_a;
                    end
                end
                default: r_state <= c_s_wait_a;
            endcase
        end
    end

    assign out_and_o    = r_and;
    assign out_or_o     = r_or;
    assign out_not_o    = r_not;
    assign result_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bool_op_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_bool_op_stream
// Brief   : Directed self-checking bench for bool_op_stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bool_op_stream;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clr_i;
    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       out_and_o;
    logic       out_or_o;
    logic       out_not_o;
    logic [7:0] result_cnt_o;

    int errors = 0;
    int checks = 0;

    bool_op_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_and_o   (out_and_o),
        .out_or_o    (out_or_o),
        .out_not_o   (out_not_o),
        .result_cnt_o(result_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic push(input logic [7:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready_o, out_valid_o, out_and_o, out_or_o, out_not_o} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10000",
                     {in_ready_o, out_valid_o, out_and_o, out_or_o, out_not_o});
        end
        checks++;
        if (result_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", result_cnt_o);
        end
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1;
        push(8'h3D);
        push(8'hA6);
        checks++;
        if ({out_valid_o, in_ready_o, out_and_o, out_or_o, out_not_o} !== 5'b10110) begin
            errors++;
            $display("FAIL basic_result: got %b want 10110",
                     {out_valid_o, in_ready_o, out_and_o, out_or_o, out_not_o});
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || result_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL basic_done: valid=%b cnt=%0d want valid=0 cnt=1", out_valid_o, result_cnt_o);
        end
    endtask

    task automatic test_zero_operands();
        logic [7:0] va [3] = '{8'h00, 8'h01, 8'h00};
        logic [7:0] vb [3] = '{8'h80, 8'h00, 8'h00};
        logic [2:0] ex [3] = '{3'b011, 3'b010, 3'b001};
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(va[i]);
            push(vb[i]);
            checks++;
            if (out_valid_o !== 1'b1 || {out_and_o, out_or_o, out_not_o} !== ex[i]) begin
                errors++;
                $display("FAIL zero_pair%0d: valid=%b aon=%b want valid=1 aon=%b",
                         i, out_valid_o, {out_and_o, out_or_o, out_not_o}, ex[i]);
            end
            tick();
            checks++;
            if (result_cnt_o !== 8'(2 + i)) begin
                errors++;
                $display("FAIL zero_cnt%0d: got %0d want %0d", i, result_cnt_o, 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        push(8'h5A);
        push(8'h00);
        in_valid_i = 1'b1;
        in_data_i  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid_o, in_ready_o, out_and_o, out_or_o, out_not_o} !== 5'b10010
                || result_cnt_o !== 8'd4) begin
                errors++;
                $display("FAIL bp_hold%0d: flags=%b cnt=%0d want flags=10010 cnt=4", i,
                         {out_valid_o, in_ready_o, out_and_o, out_or_o, out_not_o}, result_cnt_o);
            end
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || result_cnt_o !== 8'd5) begin
            errors++;
            $display("FAIL bp_release: valid=%b cnt=%0d want valid=0 cnt=5", out_valid_o, result_cnt_o);
        end
        push(8'h00);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_byte: valid=%b want 0 after one byte", out_valid_o);
        end
        push(8'h00);
        checks++;
        if (out_valid_o !== 1'b1 || {out_and_o, out_or_o, out_not_o} !== 3'b001) begin
            errors++;
            $display("FAIL bp_next_pair: valid=%b aon=%b want valid=1 aon=001",
                     out_valid_o, {out_and_o, out_or_o, out_not_o});
        end
        tick();
    endtask

    task automatic test_clear();
        out_ready_i = 1'b0;
        push(8'hFF);
        clr_i      = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 8'h11;
        tick();
        clr_i      = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if ({in_ready_o, out_valid_o, out_and_o, out_or_o, out_not_o} !== 5'b10001
            || result_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL clr_mid_pair: flags=%b cnt=%0d want flags=10001 cnt=0",
                     {in_ready_o, out_valid_o, out_and_o, out_or_o, out_not_o}, result_cnt_o);
        end
        push(8'h00);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_state: valid=%b want 0 after first byte", out_valid_o);
        end
        push(8'h05);
        checks++;
        if (out_valid_o !== 1'b1 || {out_and_o, out_or_o, out_not_o} !== 3'b011) begin
            errors++;
            $display("FAIL clr_old_a: valid=%b aon=%b want valid=1 aon=011",
                     out_valid_o, {out_and_o, out_or_o, out_not_o});
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (result_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL clr_cnt_after: got %0d want 1", result_cnt_o);
        end
        // A clear during OUT must win over a simultaneous accept.
        out_ready_i = 1'b0;
        push(8'h01);
        push(8'h02);
        clr_i       = 1'b1;
        out_ready_i = 1'b1;
        tick();
        clr_i = 1'b0;
        checks++;
        if ({out_valid_o, out_and_o, out_or_o, out_not_o} !== 4'b0110 || result_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL clr_in_out: flags=%b cnt=%0d want flags=0110 cnt=0",
                     {out_valid_o, out_and_o, out_or_o, out_not_o}, result_cnt_o);
        end
    endtask

    task automatic test_wrap();
        out_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push(8'(i));
            push(8'(i + 1));
            tick();
            if (i == 254) begin
                checks++;
                if (result_cnt_o !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: got %0d want 255", result_cnt_o);
                end
            end
        end
        checks++;
        if (result_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: got %0d want 0", result_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        push(8'h07);
        push(8'h09);
        checks++;
        if ({out_valid_o, out_and_o} !== 2'b11) begin
            errors++;
            $display("FAIL ar_setup: got %b want 11", {out_valid_o, out_and_o});
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({in_ready_o, out_valid_o, out_and_o, out_or_o, out_not_o} !== 5'b10000
            || result_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL ar_immediate: flags=%b cnt=%0d want flags=10000 cnt=0",
                     {in_ready_o, out_valid_o, out_and_o, out_or_o, out_not_o}, result_cnt_o);
        end
        @(negedge clk_i);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || out_and_o !== 1'b0) begin
            errors++;
            $display("FAIL ar_stale: valid=%b and=%b want 0 0", out_valid_o, out_and_o);
        end
        out_ready_i = 1'b0;
        push(8'h00);
        push(8'h00);
        checks++;
        if (out_valid_o !== 1'b1 || {out_and_o, out_or_o, out_not_o} !== 3'b001) begin
            errors++;
            $display("FAIL ar_resume: valid=%b aon=%b want valid=1 aon=001",
                     out_valid_o, {out_and_o, out_or_o, out_not_o});
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        clr_i       = 1'b0;
        in_data_i   = 8'h00;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #12;
        test_reset();
        rst_ni = 1'b1;
        tick();
        test_basic();
        test_zero_operands();
        test_backpressure();
        test_clear();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bool_op_stream.md
# bool_op_stream

Streaming front-end for the 8-bit logical-operator datapath. It accepts operand bytes one at a time over a valid/ready input stream, pairing the first byte as operand A and the second as operand B. It evaluates the boolean (non-bitwise) AND, OR and NOT of the pair and presents the three results as a registered, handshaked output beat. It also keeps a wrapping count of delivered results. It sits between a byte source (UART/stimulus FIFO) and any consumer of boolean flags.

## Interface

- DATA_W, default 8: operand width in bits.
- CNT_W, default 8: width of the result counter.

- clk_i  input  1: single clock, rising edge.
- rst_ni  input  1: asynchronous active-low reset.
- clr_i  input  1: synchronous clear; drops any partial pair and zeroes the counter.
- in_data_i  input  DATA_W: operand byte.
- in_valid_i  input  1: in_data_i is valid.
- in_ready_o  output  1: block can accept a byte this cycle.
- out_valid_o  output  1: result beat is valid.
- out_ready_i  input  1: consumer accepts the result beat.
- out_and_o  output  1: (A != 0) && (B != 0).
- out_or_o  output  1: (A != 0) || (B != 0).
- out_not_o  output  1: (A == 0).
- result_cnt_o  output  CNT_W: number of result beats delivered, modulo 2^CNT_W.

## Operation

- FSM states:
  - WAIT_A: in_ready_o=1, out_valid_o=0.
  - WAIT_B: in_ready_o=1, out_valid_o=0.
  - OUT: in_ready_o=0, out_valid_o=1.
- Transfer rules:
  - An input transfer happens on in_valid_i && in_ready_o at a rising edge.
  - An output transfer happens on out_valid_o && out_ready_i at a rising edge.
- WAIT_A: on input transfer, register in_data_i as A and go to WAIT_B. Otherwise stay.
- WAIT_B: on input transfer, compute the three results from the stored A and in_data_i and register them into out_*_o. Go to OUT. Operand B itself is not stored.
- OUT: hold out_*_o stable until the output transfer. On transfer, increment result_cnt_o and go to WAIT_A.
- Reductions are full-width: an operand is "true" if any of its DATA_W bits is 1.
- result_cnt_o wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- clr_i takes priority over all transfers in the same cycle:
  - state goes to WAIT_A, result_cnt_o goes to 0, and the stored A is discarded;
  - out_*_o are held at their current values, and out_valid_o drops.
  - A byte presented with clr_i high is not consumed.
  - A result presented with clr_i high counts as not delivered, even if out_ready_i=1.
- Async reset (rst_ni=0), effective immediately and in any state:
  - state = WAIT_A;
  - in_ready_o = 1;
  - out_valid_o = 0;
  - out_and_o = 0, out_or_o = 0, out_not_o = 0;
  - result_cnt_o = 0;
  - stored A = 0.
- in_ready_o and out_valid_o are decoded from the state register only. They have no combinational path from in_valid_i or out_ready_i.

## Timing

- Latency: the B byte accepted at edge N gives out_valid_o=1 and valid results after edge N.
- Maximum throughput is one result per 3 cycles (A, B, OUT); there is no overlap between OUT and the next A.
- Backpressure: out_valid_o and out_*_o stay stable for any number of cycles while out_ready_i=0.
- in_data_i is sampled only on an input transfer. Changes while in_ready_o=0 are ignored.
- result_cnt_o updates on the edge that completes the output transfer and is visible the next cycle.
- Reset deassertion is synchronised externally. The first input transfer is allowed on the first edge after rst_ni rises.

## Test plan

- Basic pair: send 8'h3D then 8'hA6, out_ready_i=1.
  - Expect out_and=1, out_or=1, out_not=0.
  - Expect out_valid_o high for exactly 1 cycle and result_cnt_o=1.
- Zero operands, three pairs:
  - A=8'h00, B=8'h80 -> and=0, or=1, not=1.
  - A=8'h01, B=8'h00 -> and=0, or=1, not=0.
  - A=8'h00, B=8'h00 -> and=0, or=0, not=1.
- Backpressure: hold out_ready_i=0 for 5 cycles after a result.
  - Expect outputs stable, in_ready_o=0, a stalled in_valid_i byte not consumed.
  - Expect the count to change only after out_ready_i rises.
- Clear mid-pair: send A=8'hFF, then assert clr_i in WAIT_B with in_valid_i=1 and in_data_i=8'h11.
  - Expect the byte not consumed and result_cnt_o=0.
  - Next pair 8'h00, 8'h05 -> not=1 (the old A is discarded).
- Counter wrap: deliver 256 results with CNT_W=8; expect result_cnt_o=0 afterwards.
- Async reset in OUT: pull rst_ni low between edges.
  - Expect out_valid_o=0, all results 0, in_ready_o=1 immediately.
  - Expect no stale result after release.
